mash111_ncl: RTL and testbench

Noise-cancellation/recombination stage of the MASH 1-1-1 digital delta-sigma modulator. Sits directly downstream of the three pipelined first-order accumulator stages and consumes their carry-out bits. Aligns the pipeline skew between stages and forms the multi-bit output y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3. The result drives the divider-control path.

---
 rtl/mash111_ncl_pkg.sv | 18 +
 rtl/mash111_ncl_delay_line.sv | 39 +++
 rtl/mash111_ncl.sv | 90 +++++++++
 tb/tb_mash111_ncl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mash111_ncl_pkg.sv
// Shared definitions for the MASH 1-1-1 delta-sigma modulator.
//   Y_MIN / Y_MAX : range of the recombined output y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3
//   n_fill()      : number of enabled samples before every delay/history tap holds real data
package mash111_ncl_pkg;

    localparam int Y_MIN = -3;
    localparam int Y_MAX = 4;

    // The c1 path is the deepest at 2S registers. The second-order
    // differentiator also needs two samples of c3 history. The output
    // register adds one more stage on top of each of these.
    function automatic int n_fill(input int skew);
        int n;
        n = 2 * skew + 1;
        return (n > 3) ? n : 3;
    endfunction

endpackage

// File: rtl/mash111_ncl_delay_line.sv
// Depth-P_DEPTH, 1-bit enabled shift register with asynchronous active-low reset.
// P_DEPTH = 0 is a combinational passthrough.
//   i_clk   : clock
//   i_rst_n : asynchronous reset, active-low (clears all taps)
//   en      : shift enable
//   din     : serial input
//   dout    : din delayed by P_DEPTH enabled edges
module mash111_ncl_delay_line #(
    parameter int P_DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);

    if (P_DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{i_clk, i_rst_n, en};
        assign dout = din;
    end else begin : g_shift
        logic [P_DEPTH-1:0] taps;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                taps <= '0;
            end else if (en) begin
                taps[0] <= din;
                for (int i = 1; i < P_DEPTH; i++) begin
                    taps[i] <= taps[i-1];
                end
            end
        end

        assign dout = taps[P_DEPTH-1];
    end

endmodule

// File: rtl/mash111_ncl.sv
// MASH 1-1-1 noise-cancellation / recombination stage.
// Removes the inter-stage pipeline skew of the three accumulator carries, then forms
// y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3 as a registered signed value in -3..+4.
//   i_clk   : clock
//   i_rst_n : asynchronous reset, active-low
//   i_en    : sample enable; nothing advances while low
//   i_c1    : stage-1 carry (earliest)
//   i_c2    : stage-2 carry (P_STAGE_SKEW cycles behind i_c1)
//   i_c3    : stage-3 carry (2*P_STAGE_SKEW cycles behind i_c1)
//   o_y     : signed modulator output, registered
//   o_valid : o_y was formed from fully primed delay lines and history
module mash111_ncl
    import mash111_ncl_pkg::*;
#(
    parameter int P_STAGE_SKEW = 1,
    parameter int P_OUT_WIDTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_c1,
    input  logic                   i_c2,
    input  logic                   i_c3,
    output logic [P_OUT_WIDTH-1:0] o_y,
    output logic                   o_valid
);

    localparam int W      = P_OUT_WIDTH;
    localparam int N_FILL = n_fill(P_STAGE_SKEW);
    localparam int CNT_W  = $clog2(N_FILL + 1);
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(N_FILL);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N_FILL - 1);

    logic a1;
    logic a2;
    logic a3;
    logic a2p;
    logic a3p;
    logic a3pp;
    logic [CNT_W-1:0] fill_cnt;
    logic signed [W-1:0] y_next;

    mash111_ncl_delay_line #(.P_DEPTH(2 * P_STAGE_SKEW)) u_dl_c1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (i_en),
        .din     (i_c1),
        .dout    (a1)
    );

    mash111_ncl_delay_line #(.P_DEPTH(P_STAGE_SKEW)) u_dl_c2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (i_en),
        .din     (i_c2),
        .dout    (a2)
    );

    assign a3 = i_c3;

    function automatic logic signed [W-1:0] ext(input logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

    // The range is -3..+4, so a W-bit (W >= 4) wrap-around sum is exact.
    assign y_next = ext(a1) + ext(a2) - ext(a2p)
                  + ext(a3) - (ext(a3p) <<< 1) + ext(a3pp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a2p      <= 1'b0;
            a3p      <= 1'b0;
            a3pp     <= 1'b0;
            fill_cnt <= '0;
            o_y      <= '0;
            o_valid  <= 1'b0;
        end else if (i_en) begin
            a2p  <= a2;
            a3p  <= a3;
            a3pp <= a3p;
            o_y  <= y_next;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
            // The sample consumed on this edge has number fill_cnt+1.
            o_valid <= o_valid | (fill_cnt >= FILL_LAST);
        end
    end

endmodule

// File: tb/tb_mash111_ncl.sv
module tb_mash111_ncl;
    import mash111_ncl_pkg::*;

    logic clk;
    logic rst_n;
    logic en;
    logic c1;
    logic c2;
    logic c3;
    logic signed [3:0] y0;
    logic signed [3:0] y1;
    logic signed [3:0] y3;
    logic v0;
    logic v1;
    logic v3;

    int checks;
    int errors;
    int hc1[$];
    int hc2[$];
    int hc3[$];
    int seq_a1[$];
    int seq_a3[$];
    int seq_b1[$];
    int seq_b3[$];
    logic [2:0] stream [40];

    mash111_ncl #(.P_STAGE_SKEW(0), .P_OUT_WIDTH(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .o_y(y0), .o_valid(v0));
    mash111_ncl #(.P_STAGE_SKEW(1), .P_OUT_WIDTH(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .o_y(y1), .o_valid(v1));
    mash111_ncl #(.P_STAGE_SKEW(3), .P_OUT_WIDTH(4)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .o_y(y3), .o_valid(v3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: carries indexed by enabled-sample number since reset, 1-based.
    function automatic int hist(input int which, input int idx);
        if (idx < 1 || idx > hc1.size()) return 0;
        case (which)
            1:       return hc1[idx-1];
            2:       return hc2[idx-1];
            default: return hc3[idx-1];
        endcase
    endfunction

    function automatic int model_y(input int s);
        int n;
        n = hc1.size();
        return hist(1, n - 2*s) + hist(2, n - s) - hist(2, n - s - 1)
             + hist(3, n) - 2*hist(3, n - 1) + hist(3, n - 2);
    endfunction

    function automatic int model_valid(input int s);
        return (hc1.size() >= n_fill(s)) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("y_s0", int'(y0), model_y(0));
        check("v_s0", int'(v0), model_valid(0));
        check("y_s1", int'(y1), model_y(1));
        check("v_s1", int'(v1), model_valid(1));
        check("y_s3", int'(y3), model_y(3));
        check("v_s3", int'(v3), model_valid(3));
        check("range_s3", int'(int'(y3) >= Y_MIN && int'(y3) <= Y_MAX), 1);
    endtask

    // Drive at posedge+1, clock, sample at posedge+1 against the reference.
    task automatic cycle(input logic e, input logic b1, input logic b2, input logic b3);
        en = e; c1 = b1; c2 = b2; c3 = b3;
        @(posedge clk);
        if (e && rst_n) begin
            hc1.push_back(int'(b1));
            hc2.push_back(int'(b2));
            hc3.push_back(int'(b3));
        end
        #1;
        check_all();
    endtask

    task automatic flush();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        en = 1'b0;
        #2 rst_n = 1'b0;
        hc1.delete(); hc2.delete(); hc3.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; en = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        #1;
        check("rst_y", int'(y1), 0);
        check("rst_valid", int'(v1), 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Constant all-ones carries: y = 1, 0, 1 then 1 forever; valid at 3rd edge.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("ones_e1_y", int'(y1), 1);
        check("ones_e1_v", int'(v1), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("ones_e2_y", int'(y1), 0);
        check("ones_e2_v", int'(v1), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("ones_e3_y", int'(y1), 1);
        check("ones_e3_v", int'(v1), 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1);
            check("ones_steady", int'(y1), 1);
        end

        // c3 impulse -> +1, -2, +1, 0
        flush();
        cycle(1'b1, 1'b0, 1'b0, 1'b1); check("c3p_0", int'(y1), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c3p_1", int'(y1), -2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c3p_2", int'(y1), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c3p_3", int'(y1), 0);

        // c2 impulse -> 0, +1, -1, 0
        flush();
        cycle(1'b1, 1'b0, 1'b1, 1'b0); check("c2p_0", int'(y1), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c2p_1", int'(y1), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c2p_2", int'(y1), -1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c2p_3", int'(y1), 0);

        // c1 impulse -> 0, 0, +1, 0
        flush();
        cycle(1'b1, 1'b1, 1'b0, 1'b0); check("c1p_0", int'(y1), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c1p_1", int'(y1), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c1p_2", int'(y1), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("c1p_3", int'(y1), 0);

        // Minimum: a1=0 a2=0 a2p=1 a3=0 a3p=1 a3pp=0
        flush();
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("y_min", int'(y1), -3);

        // Maximum: a1=1 a2=1 a2p=0 a3=1 a3p=0 a3pp=1
        flush();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1); check("y_max", int'(y1), 4);

        // Asynchronous reset between edges, then re-fill.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_y1", int'(y1), 0);
        check("arst_v1", int'(v1), 0);
        check("arst_y3", int'(y3), 0);
        check("arst_v3", int'(v3), 0);
        hc1.delete(); hc2.delete(); hc3.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("refill_e1", int'(v1), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("refill_e2", int'(v1), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); check("refill_e3", int'(v1), 1);

        // Random stream, continuous enable, then replayed with enable gaps.
        for (int i = 0; i < 40; i++) stream[i] = 3'($urandom);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, stream[i][2], stream[i][1], stream[i][0]);
            seq_a1.push_back(int'(y1));
            seq_a3.push_back(int'(y3));
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            cycle(1'b1, stream[i][2], stream[i][1], stream[i][0]);
            seq_b1.push_back(int'(y1));
            seq_b3.push_back(int'(y3));
        end
        for (int i = 0; i < 40; i++) begin
            check("gap_s1", seq_b1[i], seq_a1[i]);
            check("gap_s3", seq_b3[i], seq_a3[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
